// File: rtl/data_bridge_1xn_if.sv
// Bus bundle for data_bridge_1xn: one upstream CPU data port and N_SLV
// downstream slave ports packed as flat slices (slave i occupies slice i).
interface data_bridge_1xn_if #(
    parameter int N_SLV = 3,
    parameter int SEL_W = 2
);
    logic [SEL_W-1:0]     cpu_data_sel;
    logic                 cpu_data_req;
    logic                 cpu_data_wr;
    logic [1:0]           cpu_data_size;
    logic [31:0]          cpu_data_addr;
    logic [31:0]          cpu_data_wdata;
    logic [31:0]          cpu_data_rdata;
    logic                 cpu_data_addr_ok;
    logic                 cpu_data_data_ok;

    logic [N_SLV-1:0]     slv_data_req;
    logic [N_SLV-1:0]     slv_data_wr;
    logic [2*N_SLV-1:0]   slv_data_size;
    logic [32*N_SLV-1:0]  slv_data_addr;
    logic [32*N_SLV-1:0]  slv_data_wdata;
    logic [32*N_SLV-1:0]  slv_data_rdata;
    logic [N_SLV-1:0]     slv_data_addr_ok;
    logic [N_SLV-1:0]     slv_data_data_ok;

    // Bridge view: consumes the CPU request, produces slave requests.
    modport slave (
        input  cpu_data_sel, cpu_data_req, cpu_data_wr, cpu_data_size,
               cpu_data_addr, cpu_data_wdata,
        output cpu_data_rdata, cpu_data_addr_ok, cpu_data_data_ok,
        output slv_data_req, slv_data_wr, slv_data_size, slv_data_addr,
               slv_data_wdata,
        input  slv_data_rdata, slv_data_addr_ok, slv_data_data_ok
    );

    // Environment view: CPU on one side, slave models on the other.
    modport master (
        output cpu_data_sel, cpu_data_req, cpu_data_wr, cpu_data_size,
               cpu_data_addr, cpu_data_wdata,
        input  cpu_data_rdata, cpu_data_addr_ok, cpu_data_data_ok,
        input  slv_data_req, slv_data_wr, slv_data_size, slv_data_addr,
               slv_data_wdata,
        output slv_data_rdata, slv_data_addr_ok, slv_data_data_ok
    );
endinterface

// File: rtl/data_bridge_1xn.sv
// 1-to-N data bridge: routes CPU requests to the selected slave, keeps responses
// in order. Macro BRIDGE_ERR_RESP_EN turns out-of-range selects into error responses.
module data_bridge_1xn #(
    parameter int N_SLV   = 3,
    parameter int SEL_W   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    data_bridge_1xn_if.slave  bus,
    output logic              err_flag
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0]     cnt_r;
    logic [SEL_W-1:0]     cur_r;

    logic                 sel_in_range_s;
    logic                 cnt_zero_s;
    logic                 blk_s;
    logic                 fwd_s;
    logic                 pend_s;
    logic                 oor_accept_en_s;
    logic                 sel_addr_ok_s;
    logic                 cur_data_ok_s;
    logic [31:0]          cur_rdata_s;
    logic                 err_acc_s;
    logic                 acc_slv_s;
    logic                 rsp_s;
    logic                 addr_ok_s;
    logic                 data_ok_s;
    logic [31:0]          rdata_s;

    logic [N_SLV-1:0]     slv_req_s;
    logic [N_SLV-1:0]     slv_wr_s;
    logic [2*N_SLV-1:0]   slv_size_s;
    logic [32*N_SLV-1:0]  slv_addr_s;
    logic [32*N_SLV-1:0]  slv_wdata_s;

    assign sel_in_range_s = (32'(bus.cpu_data_sel) < 32'(N_SLV));
    assign cnt_zero_s     = (cnt_r == CNT_W'(0));

    // Block on a full window, or on a target switch while anything is in flight.
    assign blk_s = (cnt_r == CNT_W'(MAX_OUT))
                 || (!cnt_zero_s && (bus.cpu_data_sel != cur_r))
                 || pend_s;
    assign fwd_s = !blk_s && sel_in_range_s;

    // Pick the addr_ok of the requested slave and the response of the current one.
    always_comb begin
        sel_addr_ok_s = 1'b0;
        cur_data_ok_s = 1'b0;
        cur_rdata_s   = 32'h0;
        for (int i = 0; i < N_SLV; i++) begin
            sel_addr_ok_s = sel_addr_ok_s
                          | (bus.slv_data_addr_ok[i] & (bus.cpu_data_sel == SEL_W'(i)));
            cur_data_ok_s = cur_data_ok_s
                          | (bus.slv_data_data_ok[i] & (cur_r == SEL_W'(i)));
            cur_rdata_s   = cur_rdata_s
                          | (bus.slv_data_rdata[i*32 +: 32] & {32{cur_r == SEL_W'(i)}});
        end
    end

    // Fan the upstream request out to the selected slice only; others stay zero.
    always_comb begin
        slv_req_s   = '0;
        slv_wr_s    = '0;
        slv_size_s  = '0;
        slv_addr_s  = '0;
        slv_wdata_s = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (fwd_s && (bus.cpu_data_sel == SEL_W'(i))) begin
                slv_req_s[i]            = bus.cpu_data_req;
                slv_wr_s[i]             = bus.cpu_data_wr;
                slv_size_s[i*2 +: 2]    = bus.cpu_data_size;
                slv_addr_s[i*32 +: 32]  = bus.cpu_data_addr;
                slv_wdata_s[i*32 +: 32] = bus.cpu_data_wdata;
            end else begin
                slv_req_s[i]            = 1'b0;
                slv_wr_s[i]             = 1'b0;
                slv_size_s[i*2 +: 2]    = 2'b00;
                slv_addr_s[i*32 +: 32]  = 32'h0;
                slv_wdata_s[i*32 +: 32] = 32'h0;
            end
        end
    end

    // An out-of-range select can only be absorbed by the bridge itself, and only idle.
    assign err_acc_s = bus.cpu_data_req && !blk_s && !sel_in_range_s
                     && cnt_zero_s && oor_accept_en_s;
    assign acc_slv_s = bus.cpu_data_req && fwd_s && sel_addr_ok_s;
    assign addr_ok_s = acc_slv_s || err_acc_s;
    assign rsp_s     = cur_data_ok_s && !cnt_zero_s;
    assign data_ok_s = resetn && (pend_s || rsp_s);
    assign rdata_s   = pend_s ? 32'h0 : cur_rdata_s;

    assign bus.cpu_data_addr_ok = addr_ok_s;
    assign bus.cpu_data_data_ok = data_ok_s;
    assign bus.cpu_data_rdata   = rdata_s;
    assign bus.slv_data_req     = slv_req_s;
    assign bus.slv_data_wr      = slv_wr_s;
    assign bus.slv_data_size    = slv_size_s;
    assign bus.slv_data_addr    = slv_addr_s;
    assign bus.slv_data_wdata   = slv_wdata_s;

    // Outstanding counter and current target; cur only ever holds an in-range index.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r <= CNT_W'(0);
            cur_r <= SEL_W'(0);
        end else begin
            if (acc_slv_s) begin
                cur_r <= bus.cpu_data_sel;
            end else begin
                cur_r <= cur_r;
            end
            if (acc_slv_s && !rsp_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else if (!acc_slv_s && rsp_s) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

`ifdef BRIDGE_ERR_RESP_EN
    logic pend_r;
    logic err_r;

    // Error response is a one-cycle pending slot plus a sticky flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            pend_r <= err_acc_s;
            err_r  <= err_r | err_acc_s;
        end
    end

    assign pend_s          = pend_r;
    assign oor_accept_en_s = 1'b1;
    assign err_flag        = err_r;
`else
    assign pend_s          = 1'b0;
    assign oor_accept_en_s = 1'b0;
    assign err_flag        = 1'b0;
`endif

endmodule

// File: tb/tb_data_bridge_1xn.sv
// Self-checking bench for data_bridge_1xn: directed scenarios plus randomized
// traffic against a queue-based reference model (honours BRIDGE_ERR_RESP_EN).
module tb_data_bridge_1xn;
    localparam int N    = 3;
    localparam int SW   = 2;
    localparam int MAXO = 4;
`ifdef BRIDGE_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic resetn;
    logic err_flag;
    int   n_tests;
    int   n_fail;

    data_bridge_1xn_if #(.N_SLV(N), .SEL_W(SW)) bus ();

    data_bridge_1xn #(.N_SLV(N), .SEL_W(SW), .MAX_OUT(MAXO)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of accepted targets plus error-pending state.
    int          q[$];
    bit          pend_m;
    bit          err_m;
    logic        exp_addr_ok;
    logic        exp_data_ok;
    logic [31:0] exp_rdata;
    logic [N-1:0]    exp_slv_req;
    logic [32*N-1:0] exp_slv_addr;

    task automatic set_idle();
        bus.cpu_data_req     = 1'b0;
        bus.cpu_data_wr      = 1'b0;
        bus.cpu_data_size    = 2'd0;
        bus.cpu_data_sel     = 2'd0;
        bus.cpu_data_addr    = 32'h0;
        bus.cpu_data_wdata   = 32'h0;
        bus.slv_data_rdata   = '0;
        bus.slv_data_addr_ok = 3'b000;
        bus.slv_data_data_ok = 3'b000;
    endtask

    task automatic model_eval();
        int s;
        bit in_rng;
        bit blk;
        s      = int'(bus.cpu_data_sel);
        in_rng = (s < N);
        blk    = (q.size() == MAXO) || (q.size() != 0 && s != q[0]) || pend_m;
        exp_slv_req  = '0;
        exp_slv_addr = '0;
        if (!blk && in_rng) begin
            exp_slv_req[s]           = bus.cpu_data_req;
            exp_slv_addr[s*32 +: 32] = bus.cpu_data_addr;
        end
        if (in_rng)
            exp_addr_ok = bus.cpu_data_req && !blk && bus.slv_data_addr_ok[s];
        else
            exp_addr_ok = bus.cpu_data_req && !blk && ERR_EN && (q.size() == 0);
        exp_data_ok = resetn && (pend_m || (q.size() != 0 && bus.slv_data_data_ok[q[0]]));
        if (pend_m)
            exp_rdata = 32'h0;
        else if (q.size() != 0)
            exp_rdata = bus.slv_data_rdata[q[0]*32 +: 32];
        else
            exp_rdata = 32'h0;
    endtask

    // Advance the model with the inputs applied this cycle, then take the edge.
    task automatic tick();
        model_eval();
        if (!resetn) begin
            q.delete();
            pend_m = 1'b0;
            err_m  = 1'b0;
        end else begin
            if (exp_data_ok && !pend_m) void'(q.pop_front());
            pend_m = 1'b0;
            if (exp_addr_ok) begin
                if (int'(bus.cpu_data_sel) < N) begin
                    q.push_back(int'(bus.cpu_data_sel));
                end else begin
                    pend_m = 1'b1;
                    err_m  = 1'b1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_idle();
        tick();
        @(negedge clk);
        bus.slv_data_data_ok = 3'b111;
        #1;
        n_tests++;
        if (bus.cpu_data_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL reset_data_ok: got %b expected 0", bus.cpu_data_data_ok);
        end
        n_tests++;
        if (err_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_err_flag: got %b expected 0", err_flag);
        end
        tick();
        resetn = 1'b1;
        @(negedge clk);
        set_idle();
        #1;
        n_tests++;
        if (bus.cpu_data_addr_ok !== 1'b0 || bus.slv_data_req !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle: addr_ok %b slv_req %b expected 0 000",
                               bus.cpu_data_addr_ok, bus.slv_data_req);
        end
        tick();
    endtask

    task automatic test_single_read();
        @(negedge clk);
        bus.cpu_data_req = 1'b1; bus.cpu_data_sel = 2'd1;
        bus.cpu_data_addr = 32'hA000_0010; bus.slv_data_addr_ok = 3'b010;
        #1;
        n_tests++;
        if (bus.cpu_data_addr_ok !== 1'b1 || bus.slv_data_req !== 3'b010
            || bus.slv_data_addr[63:32] !== 32'hA000_0010) begin
            n_fail++; $display("FAIL single_c0: addr_ok %b slv_req %b addr %h expected 1 010 a0000010",
                               bus.cpu_data_addr_ok, bus.slv_data_req, bus.slv_data_addr[63:32]);
        end
        tick();
        @(negedge clk);
        set_idle();
        #1;
        n_tests++;
        if (bus.cpu_data_data_ok !== 1'b0 || bus.slv_data_req !== 3'b000) begin
            n_fail++; $display("FAIL single_c1: data_ok %b slv_req %b expected 0 000",
                               bus.cpu_data_data_ok, bus.slv_data_req);
        end
        tick();
        @(negedge clk);
        bus.slv_data_data_ok = 3'b010;
        bus.slv_data_rdata   = {32'hDEAD_0002, 32'h1234_5678, 32'hDEAD_0000};
        #1;
        n_tests++;
        if (bus.cpu_data_data_ok !== 1'b1 || bus.cpu_data_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL single_c2: data_ok %b rdata %h expected 1 12345678",
                               bus.cpu_data_data_ok, bus.cpu_data_rdata);
        end
        tick();
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_max_out();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.cpu_data_req = 1'b1; bus.cpu_data_sel = 2'd0;
            bus.cpu_data_addr = 32'h100 + 32'(k); bus.slv_data_addr_ok = 3'b001;
            #1;
            n_tests++;
            if (bus.cpu_data_addr_ok !== ((k < 4) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL max_out_acc%0d: got %b expected %b", k,
                                   bus.cpu_data_addr_ok, (k < 4) ? 1'b1 : 1'b0);
            end
            tick();
        end
        @(negedge clk);
        bus.slv_data_data_ok = 3'b001;
        #1;
        n_tests++;
        if (bus.cpu_data_addr_ok !== 1'b0 || bus.cpu_data_data_ok !== 1'b1) begin
            n_fail++; $display("FAIL max_out_full_rsp: addr_ok %b data_ok %b expected 0 1",
                               bus.cpu_data_addr_ok, bus.cpu_data_data_ok);
        end
        tick();
        @(negedge clk);
        bus.slv_data_data_ok = 3'b000;
        #1;
        n_tests++;
        if (bus.cpu_data_addr_ok !== 1'b1) begin
            n_fail++; $display("FAIL max_out_fifth: addr_ok %b expected 1", bus.cpu_data_addr_ok);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_idle();
            bus.slv_data_data_ok = 3'b001;
            #1;
            n_tests++;
            if (bus.cpu_data_data_ok !== 1'b1) begin
                n_fail++; $display("FAIL max_out_drain%0d: data_ok %b expected 1", k, bus.cpu_data_data_ok);
            end
            tick();
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_switch();
        @(negedge clk);
        bus.cpu_data_req = 1'b1; bus.cpu_data_sel = 2'd0; bus.slv_data_addr_ok = 3'b101;
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.cpu_data_sel = 2'd2;
            bus.slv_data_data_ok = (k == 1) ? 3'b001 : 3'b000;
            #1;
            n_tests++;
            if (bus.cpu_data_addr_ok !== 1'b0 || bus.slv_data_req !== 3'b000
                || bus.cpu_data_data_ok !== ((k == 1) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL switch_block%0d: addr_ok %b slv_req %b data_ok %b expected 0 000 %b",
                                   k, bus.cpu_data_addr_ok, bus.slv_data_req, bus.cpu_data_data_ok, k == 1);
            end
            tick();
        end
        @(negedge clk);
        bus.slv_data_data_ok = 3'b000;
        #1;
        n_tests++;
        if (bus.cpu_data_addr_ok !== 1'b1 || bus.slv_data_req !== 3'b100) begin
            n_fail++; $display("FAIL switch_accept: addr_ok %b slv_req %b expected 1 100",
                               bus.cpu_data_addr_ok, bus.slv_data_req);
        end
        tick();
        @(negedge clk);
        set_idle();
        bus.slv_data_data_ok = 3'b100;
        #1;
        n_tests++;
        if (bus.cpu_data_data_ok !== 1'b1) begin
            n_fail++; $display("FAIL switch_rsp: data_ok %b expected 1", bus.cpu_data_data_ok);
        end
        tick();
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        bus.cpu_data_req = 1'b1; bus.cpu_data_sel = 2'd0; bus.slv_data_addr_ok = 3'b001;
        tick();
        tick();
        @(negedge clk);
        bus.slv_data_data_ok = 3'b001;
        #1;
        n_tests++;
        if (bus.cpu_data_addr_ok !== 1'b1 || bus.cpu_data_data_ok !== 1'b1) begin
            n_fail++; $display("FAIL simul_acc_rsp: addr_ok %b data_ok %b expected 1 1",
                               bus.cpu_data_addr_ok, bus.cpu_data_data_ok);
        end
        tick();
        @(negedge clk);
        set_idle();
        bus.slv_data_data_ok = 3'b010;
        #1;
        n_tests++;
        if (bus.cpu_data_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL simul_spurious: data_ok %b expected 0", bus.cpu_data_data_ok);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.slv_data_data_ok = 3'b001;
            #1;
            n_tests++;
            if (bus.cpu_data_data_ok !== ((k < 2) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL simul_drain%0d: data_ok %b expected %b", k,
                                   bus.cpu_data_data_ok, (k < 2) ? 1'b1 : 1'b0);
            end
            tick();
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        bus.cpu_data_req = 1'b1; bus.cpu_data_sel = 2'd3; bus.slv_data_addr_ok = 3'b111;
        #1;
        n_tests++;
        if (bus.cpu_data_addr_ok !== ERR_EN || bus.slv_data_req !== 3'b000) begin
            n_fail++; $display("FAIL oor_c0: addr_ok %b slv_req %b expected %b 000",
                               bus.cpu_data_addr_ok, bus.slv_data_req, ERR_EN);
        end
        tick();
`ifdef BRIDGE_ERR_RESP_EN
        @(negedge clk);
        bus.cpu_data_sel = 2'd0;
        bus.slv_data_rdata = {3{32'hFFFF_FFFF}};
        #1;
        n_tests++;
        if (bus.cpu_data_data_ok !== 1'b1 || bus.cpu_data_rdata !== 32'h0
            || bus.cpu_data_addr_ok !== 1'b0 || err_flag !== 1'b1) begin
            n_fail++; $display("FAIL oor_err_rsp: data_ok %b rdata %h addr_ok %b err %b expected 1 0 0 1",
                               bus.cpu_data_data_ok, bus.cpu_data_rdata, bus.cpu_data_addr_ok, err_flag);
        end
        tick();
        @(negedge clk);
        set_idle();
        #1;
        n_tests++;
        if (bus.cpu_data_data_ok !== 1'b0 || err_flag !== 1'b1) begin
            n_fail++; $display("FAIL oor_sticky: data_ok %b err %b expected 0 1",
                               bus.cpu_data_data_ok, err_flag);
        end
        tick();
`else
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (bus.cpu_data_addr_ok !== 1'b0 || err_flag !== 1'b0 || bus.slv_data_req !== 3'b000) begin
                n_fail++; $display("FAIL oor_stall%0d: addr_ok %b err %b slv_req %b expected 0 0 000",
                                   k, bus.cpu_data_addr_ok, err_flag, bus.slv_data_req);
            end
            tick();
        end
        @(negedge clk);
        set_idle();
`endif
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        bus.cpu_data_req = 1'b1; bus.cpu_data_sel = 2'd0; bus.slv_data_addr_ok = 3'b001;
        tick(); tick(); tick();
        @(negedge clk);
        set_idle();
        resetn = 1'b0;
        bus.slv_data_data_ok = 3'b001;
        #1;
        n_tests++;
        if (bus.cpu_data_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL rst_inflight_during: data_ok %b expected 0", bus.cpu_data_data_ok);
        end
        tick();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_tests++;
        if (bus.cpu_data_data_ok !== 1'b0 || err_flag !== 1'b0) begin
            n_fail++; $display("FAIL rst_inflight_after: data_ok %b err %b expected 0 0",
                               bus.cpu_data_data_ok, err_flag);
        end
        tick();
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_random();
        logic [SW-1:0] sel_v;
        sel_v = 2'd0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) < 3) begin
                if ($urandom_range(0, 7) == 0) sel_v = 2'd3;
                else sel_v = SW'($urandom_range(0, N - 1));
            end
            bus.cpu_data_sel     = sel_v;
            bus.cpu_data_req     = ($urandom_range(0, 3) != 0);
            bus.cpu_data_wr      = 1'($urandom);
            bus.cpu_data_size    = 2'($urandom);
            bus.cpu_data_addr    = $urandom;
            bus.cpu_data_wdata   = $urandom;
            bus.slv_data_rdata   = {$urandom, $urandom, $urandom};
            bus.slv_data_addr_ok = 3'($urandom);
            bus.slv_data_data_ok = 3'($urandom);
            #1;
            model_eval();
            n_tests++;
            if (bus.cpu_data_addr_ok !== exp_addr_ok || bus.cpu_data_data_ok !== exp_data_ok) begin
                n_fail++; $display("FAIL rand_hs c%0d: addr_ok %b data_ok %b expected %b %b", c,
                                   bus.cpu_data_addr_ok, bus.cpu_data_data_ok, exp_addr_ok, exp_data_ok);
            end
            if (exp_data_ok) begin
                n_tests++;
                if (bus.cpu_data_rdata !== exp_rdata) begin
                    n_fail++; $display("FAIL rand_rdata c%0d: got %h expected %h", c,
                                       bus.cpu_data_rdata, exp_rdata);
                end
            end
            n_tests++;
            if (bus.slv_data_req !== exp_slv_req || bus.slv_data_addr !== exp_slv_addr) begin
                n_fail++; $display("FAIL rand_fwd c%0d: slv_req %b addr %h expected %b %h", c,
                                   bus.slv_data_req, bus.slv_data_addr, exp_slv_req, exp_slv_addr);
            end
            n_tests++;
            if (err_flag !== err_m) begin
                n_fail++; $display("FAIL rand_err c%0d: got %b expected %b", c, err_flag, err_m);
            end
            tick();
        end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        clk     = 1'b0;
        resetn  = 1'b0;
        n_tests = 0;
        n_fail  = 0;
        pend_m  = 1'b0;
        err_m   = 1'b0;
        set_idle();
        test_reset();
        test_single_read();
        test_max_out();
        test_switch();
        test_simultaneous();
        test_out_of_range();
        test_reset_inflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
